// File: rtl/dmem_param.sv
// dmem_param: parametrised, byte-addressed, big-endian data memory.
//
// Sits between the CPU load/store unit and the bus stub. One access per
// cycle, registered read (1-cycle latency) with an rvalid strobe, range and
// optional alignment checking, and a sticky capture of the first faulting
// address.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   rena       in   read request
//   wena       in   write request
//   select     in   [1:0] 01 byte, 10 halfword, 11 word, 00 no access
//   sign_ext   in   loads: 1 sign-extend, 0 zero-extend
//   addr       in   [31:0] CPU byte address
//   data_in    in   [31:0] store data, right-justified
//   data_out   out  [31:0] load data, right-justified and extended
//   rvalid     out  one-cycle pulse, data_out valid
//   addr_err   out  one-cycle pulse, access out of range
//   align_err  out  one-cycle pulse, access misaligned (in range)
//   err_sticky out  set by any fault, cleared by err_clr
//   err_addr   out  [31:0] address of first fault since last clear
//   err_clr    in   clears err_sticky / err_addr (a same-cycle fault wins)
module dmem_param #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rena,
  input  logic        wena,
  input  logic [1:0]  select,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rvalid,
  output logic        addr_err,
  output logic        align_err,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0] mem [DEPTH_BYTES];

  logic [31:0]   off;
  logic [2:0]    size;
  logic [32:0]   end_off;
  logic          in_range;
  logic          misalign;
  logic          access;
  logic          rd_acc;
  logic          addr_fault;
  logic          align_fault;
  logic          fault;
  logic          wr_ok;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   rdata;

  logic [31:0] data_out_q, data_out_d;
  logic        rvalid_q, rvalid_d;
  logic        addr_err_q, addr_err_d;
  logic        align_err_q, align_err_d;
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] err_addr_q, err_addr_d;

  always_comb begin
    off = addr - BASE_ADDR;  // below-base addresses wrap to huge offsets
    case (select)
      2'b01:   size = 3'd1;
      2'b10:   size = 3'd2;
      2'b11:   size = 3'd4;
      default: size = 3'd0;
    endcase
    // 33-bit sum so off near 2^32 cannot wrap back into range
    end_off  = {1'b0, off} + {30'b0, size};
    in_range = (end_off <= 33'(DEPTH_BYTES));
    misalign = CHECK_ALIGN &&
               (((select == 2'b10) && off[0]) ||
                ((select == 2'b11) && (off[1:0] != 2'b00)));
    access      = (rena || wena) && (select != 2'b00);
    rd_acc      = rena && (select != 2'b00);
    addr_fault  = access && !in_range;
    align_fault = access && in_range && misalign;  // range fault has priority
    fault       = addr_fault || align_fault;
    wr_ok       = wena && access && !fault;
  end

  // Byte indices wrap within the array; only used when the access is in
  // range, otherwise the result is discarded.
  always_comb begin
    idx0 = off[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    b0   = mem[idx0];
    b1   = mem[idx1];
    b2   = mem[idx2];
    b3   = mem[idx3];
    case (select)
      2'b01:   rdata = {{24{sign_ext & b0[7]}}, b0};
      2'b10:   rdata = {{16{sign_ext & b0[7]}}, b0, b1};
      2'b11:   rdata = {b0, b1, b2, b3};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    data_out_d   = data_out_q;
    rvalid_d     = rd_acc;
    addr_err_d   = addr_fault;
    align_err_d  = align_fault;
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    if (rd_acc) begin
      data_out_d = fault ? 32'h0 : rdata;
    end
    if (fault && (!err_sticky_q || err_clr)) begin
      err_sticky_d = 1'b1;
      err_addr_d   = addr;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
      err_addr_d   = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out_q   <= 32'h0;
      rvalid_q     <= 1'b0;
      addr_err_q   <= 1'b0;
      align_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_addr_q   <= 32'h0;
    end else begin
      data_out_q   <= data_out_d;
      rvalid_q     <= rvalid_d;
      addr_err_q   <= addr_err_d;
      align_err_q  <= align_err_d;
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Storage is not reset, but a write presented during reset is dropped.
  // Reads above use the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      case (select)
        2'b01: mem[idx0] <= data_in[7:0];
        2'b10: begin
          mem[idx0] <= data_in[15:8];
          mem[idx1] <= data_in[7:0];
        end
        2'b11: begin
          mem[idx0] <= data_in[31:24];
          mem[idx1] <= data_in[23:16];
          mem[idx2] <= data_in[15:8];
          mem[idx3] <= data_in[7:0];
        end
        default: ;
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign rvalid     = rvalid_q;
  assign addr_err   = addr_err_q;
  assign align_err  = align_err_q;
  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;

endmodule
